// File: rtl/tdm_demux16.sv
// Receive side of the TDM slot path: locks to frame_sync, steers each beat into a
// shadow lane selected by an internal slot counter, and publishes whole frames on y.
module tdm_demux16 #(
  parameter int WIDTH  = 1,
  parameter int NSLOTS = 16,
  parameter int SW     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic                    frame_sync,
  output logic [NSLOTS*WIDTH-1:0] y,
  output logic                    frame_done,
  output logic                    sync_err,
  output logic [SW-1:0]           slot,
  output logic                    locked
);

  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [SW-1:0] LAST = SW'(NSLOTS - 1);

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         shadow [NSLOTS-1];
  logic [SW-1:0]            slot_nxt;
  logic [SW-1:0]            wr_idx;
  logic                     wr_en;
  logic                     done_nxt;
  logic                     err_nxt;
  logic [NSLOTS*WIDTH-1:0]  y_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr_en     = 1'b0;
    wr_idx    = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            wr_en     = 1'b1;
            slot_nxt  = SW'(1);
            state_nxt = RUN;
          end
        end
        RUN: begin
          // A sync beat anywhere but slot 0 (including the last slot) restarts the frame.
          if (frame_sync && slot != '0) begin
            err_nxt  = 1'b1;
            wr_en    = 1'b1;
            slot_nxt = SW'(1);
          end else if (slot == LAST) begin
            done_nxt = 1'b1;
            slot_nxt = '0;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = slot;
            slot_nxt = slot + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The top lane is never stored: it comes straight from din on the completing beat.
  always_comb begin
    y_frame = '0;
    for (int unsigned k = 0; k < NSLOTS - 1; k++)
      y_frame[k*WIDTH +: WIDTH] = shadow[k];
    y_frame[(NSLOTS-1)*WIDTH +: WIDTH] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y          <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      slot       <= '0;
      for (int unsigned k = 0; k < NSLOTS - 1; k++)
        shadow[k] <= '0;
    end else begin
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
      slot       <= slot_nxt;
      if (done_nxt)
        y <= y_frame;
      for (int unsigned k = 0; k < NSLOTS - 1; k++)
        if (wr_en && wr_idx == SW'(k))
          shadow[k] <= din;
    end
  end

  assign locked = (state == RUN);

endmodule
